// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the shared ALU: accepts one packed instruction,
// drives registered operands to the ALU, then writes the result back to a 16-entry register file.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef OP_ADD
`define OP_ADD 4'h0
`endif
`ifndef OP_SUB
`define OP_SUB 4'h1
`endif
`ifndef OP_MUL
`define OP_MUL 4'h2
`endif
`ifndef OP_CMP
`define OP_CMP 4'h3
`endif

module alu_issue_ctrl #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int MUL_EXTRA  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [23:0]           instr,
  output logic [3:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_operand_a,
  output logic [DATA_WIDTH-1:0] alu_operand_b,
  output logic [7:0]            alu_immediate,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_cmp_flag,
  input  logic                  host_we,
  input  logic [3:0]            host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  input  logic [3:0]            dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  cmp_flag,
  output logic                  done,
  output logic                  illegal,
  output logic [1:0]            dbg_state
);

  // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
  // the initiator must hold instr stable while instr_valid is high and instr_ready is low.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_EXEC = 2'd2, S_WB = 2'd3} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [23:0]           r_instr;
  logic [2:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_res;
  logic                  r_flag;
  logic [DATA_WIDTH-1:0] r_regs [16];

  logic [3:0] w_op;
  logic [3:0] w_rd;
  logic [3:0] w_rs;
  logic [3:0] w_rt;
  logic       w_is_arith;
  logic       w_is_cmp;
  logic       w_accept;

  assign w_op       = r_instr[23:20];
  assign w_rd       = r_instr[19:16];
  assign w_rs       = r_instr[15:12];
  assign w_rt       = r_instr[11:8];
  assign w_is_arith = (w_op == `OP_ADD) || (w_op == `OP_SUB) || (w_op == `OP_MUL);
  assign w_is_cmp   = (w_op == `OP_CMP);
  assign w_accept   = instr_valid && instr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_READ;
      S_READ: w_next = S_EXEC;
      S_EXEC: if (r_cnt == 3'd0) w_next = S_WB;
      S_WB:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (r_state == S_IDLE);
    done        = (r_state == S_WB);
    illegal     = (r_state == S_WB) && !w_is_arith && !w_is_cmp;
    dbg_state   = r_state;
  end

  // Datapath: instruction latch, ALU drive registers, EXEC counter and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr       <= '0;
      r_cnt         <= '0;
      r_res         <= '0;
      r_flag        <= 1'b0;
      alu_opcode    <= '0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_immediate <= '0;
      cmp_flag      <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_accept) r_instr <= instr;
      if (r_state == S_READ) begin
        alu_opcode    <= w_op;
        alu_operand_a <= r_regs[w_rs];
        alu_operand_b <= r_regs[w_rt];
        alu_immediate <= r_instr[7:0];
        r_cnt         <= (w_op == `OP_MUL) ? 3'(MUL_EXTRA) : 3'd0;
      end
      if (r_state == S_EXEC) begin
        if (r_cnt == 3'd0) begin
          r_res  <= alu_result;
          r_flag <= alu_cmp_flag;
        end else begin
          r_cnt <= r_cnt - 3'd1;
        end
      end
      if (r_state == S_WB && w_is_cmp) cmp_flag <= r_flag;
    end
  end

  // Writeback is assigned after the host write so it takes priority on the same register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      if (host_we) r_regs[host_addr] <= host_wdata;
      if (r_state == S_WB && w_is_arith) r_regs[w_rd] <= r_res;
    end
  end

  assign dbg_rdata = r_regs[dbg_addr];

endmodule
